uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_tick_cnt.sv | 40 ++++
 rtl/uart_tx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmitter: FSM encodings, parameter defaults
// and parity-type selectors.
package uart_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int OVERSAMPLE_DEF = 16;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   typedef logic [2:0] state_t;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   // Counter width that never collapses to zero bits for degenerate sizes.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_tick_cnt.sv
// Oversample tick counter: counts TX_tick pulses while a frame is running and
// flags the tick that closes each bit period.
module uart_tx_tick_cnt
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
)(
   input  logic CLK,
   input  logic RST,
   input  logic TX_tick,
   input  logic clear,
   input  logic run,
   output logic bit_end
);

   localparam int               CNT_W   = cnt_width(OVERSAMPLE);
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(OVERSAMPLE - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign bit_end = run && TX_tick && (cnt_q == CNT_TOP);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (run && TX_tick) begin
         cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first payload, optional parity, one stop bit,
// all timed from an external oversample tick.
//
//   state    | meaning
//   ---------+---------------------------------------------
//   S_IDLE   | line high, waiting for DATA_VALID
//   S_START  | driving start bit (0)
//   S_DATA   | driving payload bit idx_q
//   S_PARITY | driving parity bit of the latched payload
//   S_STOP   | driving stop bit (1); TX_DONE fires as it ends
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
)(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  TX_tick,
   input  logic [DATA_WIDTH-1:0] DATA_IN,
   input  logic                  DATA_VALID,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  BUSY,
   output logic                  TX_DONE
);

   localparam int               IDX_W    = cnt_width(DATA_WIDTH);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  par_en_q, par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  accept;
   logic                  bit_end;
   logic                  par_bit;

   assign accept  = (state_q == S_IDLE) && DATA_VALID;
   assign par_bit = (^data_q) ^ (par_typ_q == PAR_ODD);

   // The acceptance cycle clears the counter and is not "running", so a
   // coincident tick is dropped and the start bit gets a full OVERSAMPLE ticks.
   uart_tx_tick_cnt #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_tick_cnt (
      .CLK     (CLK),
      .RST     (RST),
      .TX_tick (TX_tick),
      .clear   (accept),
      .run     (state_q != S_IDLE),
      .bit_end (bit_end)
   );

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
      idx_d     = idx_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (DATA_VALID) begin
               state_d   = S_START;
               data_d    = DATA_IN;
               par_en_d  = PAR_EN;
               par_typ_d = PAR_TYP;
               idx_d     = '0;
               tx_d      = 1'b0;
               busy_d    = 1'b1;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               idx_d   = '0;
               tx_d    = data_q[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (idx_q == IDX_LAST) begin
                  state_d = par_en_q ? S_PARITY : S_STOP;
                  tx_d    = par_en_q ? par_bit : 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
                  tx_d  = data_q[idx_d];
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               tx_d    = 1'b1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q   <= S_IDLE;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         idx_q     <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
         idx_q     <= idx_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign TX_OUT  = tx_q;
   assign BUSY    = busy_q;
   assign TX_DONE = done_q;

endmodule
